// File: rtl/time_counter_gen.sv
// Time-of-day counter: six BCD digits HH:MM:SS, advanced once per PRESCALE ticks,
// with validated loads, hold, 12/24h display and rollover strobes. Optional macro: TIME_CNT_DOWN_EN.
module time_counter_gen #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        hold,
  input  logic        mode_12h,
`ifdef TIME_CNT_DOWN_EN
  input  logic        count_down,
`endif
  output logic [23:0] time_out,
  output logic        pm,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        day_pulse,
  output logic        load_err
);

  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [3:0] hr_ms_reg, hr_ls_reg, min_ms_reg, min_ls_reg, sec_ms_reg, sec_ls_reg;
  logic [3:0] hr_ms_next, hr_ls_next, min_ms_next, min_ls_next, sec_ms_next, sec_ls_next;
  logic [PCNT_W-1:0] pcnt_reg;
  logic wrap_sec, wrap_day, down, load_ok;
  logic [5:0] digit_ok;
  logic [3:0] disp_hr_ms, disp_hr_ls;

`ifdef TIME_CNT_DOWN_EN
  assign down = count_down;
`else
  assign down = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit_ok
      assign digit_ok[gi] = (load_time[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  assign load_ok = (&digit_ok) && (load_time[23:20] <= 4'd2) &&
                   !(load_time[23:20] == 4'd2 && load_time[19:16] > 4'd3) &&
                   (load_time[15:12] <= 4'd5) && (load_time[7:4] <= 4'd5);

  // One-second step in either direction; wrap flags feed the minute/day strobes.
  always_comb begin
    hr_ms_next  = hr_ms_reg;
    hr_ls_next  = hr_ls_reg;
    min_ms_next = min_ms_reg;
    min_ls_next = min_ls_reg;
    sec_ms_next = sec_ms_reg;
    sec_ls_next = sec_ls_reg;
    wrap_sec    = 1'b0;
    wrap_day    = 1'b0;
    if (!down) begin
      if (sec_ls_reg != 4'd9) sec_ls_next = sec_ls_reg + 4'd1;
      else begin
        sec_ls_next = 4'd0;
        if (sec_ms_reg != 4'd5) sec_ms_next = sec_ms_reg + 4'd1;
        else begin
          sec_ms_next = 4'd0;
          wrap_sec    = 1'b1;
          if (min_ls_reg != 4'd9) min_ls_next = min_ls_reg + 4'd1;
          else begin
            min_ls_next = 4'd0;
            if (min_ms_reg != 4'd5) min_ms_next = min_ms_reg + 4'd1;
            else begin
              min_ms_next = 4'd0;
              if (hr_ms_reg == 4'd2 && hr_ls_reg == 4'd3) begin
                hr_ms_next = 4'd0;
                hr_ls_next = 4'd0;
                wrap_day   = 1'b1;
              end else if (hr_ls_reg == 4'd9) begin
                hr_ls_next = 4'd0;
                hr_ms_next = hr_ms_reg + 4'd1;
              end else hr_ls_next = hr_ls_reg + 4'd1;
            end
          end
        end
      end
    end else begin
      if (sec_ls_reg != 4'd0) sec_ls_next = sec_ls_reg - 4'd1;
      else begin
        sec_ls_next = 4'd9;
        if (sec_ms_reg != 4'd0) sec_ms_next = sec_ms_reg - 4'd1;
        else begin
          sec_ms_next = 4'd5;
          wrap_sec    = 1'b1;
          if (min_ls_reg != 4'd0) min_ls_next = min_ls_reg - 4'd1;
          else begin
            min_ls_next = 4'd9;
            if (min_ms_reg != 4'd0) min_ms_next = min_ms_reg - 4'd1;
            else begin
              min_ms_next = 4'd5;
              if (hr_ms_reg == 4'd0 && hr_ls_reg == 4'd0) begin
                hr_ms_next = 4'd2;
                hr_ls_next = 4'd3;
                wrap_day   = 1'b1;
              end else if (hr_ls_reg == 4'd0) begin
                hr_ls_next = 4'd9;
                hr_ms_next = hr_ms_reg - 4'd1;
              end else hr_ls_next = hr_ls_reg - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {hr_ms_reg, hr_ls_reg, min_ms_reg, min_ls_reg, sec_ms_reg, sec_ls_reg} <= 24'h0;
      pcnt_reg  <= '0;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        if (load_ok) begin
          {hr_ms_reg, hr_ls_reg, min_ms_reg, min_ls_reg, sec_ms_reg, sec_ls_reg} <= load_time;
          pcnt_reg <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (!hold && tick) begin
        if (pcnt_reg == PCNT_LAST) begin
          pcnt_reg   <= '0;
          hr_ms_reg  <= hr_ms_next;
          hr_ls_reg  <= hr_ls_next;
          min_ms_reg <= min_ms_next;
          min_ls_reg <= min_ls_next;
          sec_ms_reg <= sec_ms_next;
          sec_ls_reg <= sec_ls_next;
          sec_pulse  <= 1'b1;
          min_pulse  <= wrap_sec;
          day_pulse  <= wrap_day;
        end else begin
          pcnt_reg <= pcnt_reg + PCNT_W'(1);
        end
      end
    end
  end

  assign pm = (hr_ms_reg == 4'd2) || (hr_ms_reg == 4'd1 && hr_ls_reg >= 4'd2);

  // 12h mapping done digit-wise in BCD: 00->12, 13-19->01-07, 20-21->08-09, 22-23->10-11.
  always_comb begin
    disp_hr_ms = hr_ms_reg;
    disp_hr_ls = hr_ls_reg;
    if (mode_12h) begin
      if (hr_ms_reg == 4'd0 && hr_ls_reg == 4'd0) begin
        disp_hr_ms = 4'd1;
        disp_hr_ls = 4'd2;
      end else if (hr_ms_reg == 4'd1 && hr_ls_reg >= 4'd3) begin
        disp_hr_ms = 4'd0;
        disp_hr_ls = hr_ls_reg - 4'd2;
      end else if (hr_ms_reg == 4'd2 && hr_ls_reg <= 4'd1) begin
        disp_hr_ms = 4'd0;
        disp_hr_ls = hr_ls_reg + 4'd8;
      end else if (hr_ms_reg == 4'd2) begin
        disp_hr_ms = 4'd1;
        disp_hr_ls = hr_ls_reg - 4'd2;
      end
    end
  end

  assign time_out = {disp_hr_ms, disp_hr_ls, min_ms_reg, min_ls_reg, sec_ms_reg, sec_ls_reg};

endmodule

// File: doc/time_counter_gen.md
Name: time_counter_gen

Overview:
Parametrised successor to the alarm-clock HH:MM current-time counter. Holds time of day as six BCD digits (HH:MM:SS) and advances one second for every PRESCALE qualified ticks. Adds seconds, 12/24-hour display mode, validated loads, hold, and rollover pulses for alarm compare and date logic. Sits between the tick generator and the display/alarm-compare units.

Parameters:
PRESCALE, 1, number of qualified tick pulses per one-second advance; must be >= 1.
PCNT_W, $clog2(PRESCALE) with a minimum of 1, width of the internal prescale counter. Derived; not overridden.

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clk
tick  in  1  base time-tick strobe, one clk cycle wide
load  in  1  load load_time into the time state
load_time  in  24  BCD {hr_ms,hr_ls,min_ms,min_ls,sec_ms,sec_ls}, always 24-hour format
hold  in  1  freeze counting and prescaler
mode_12h  in  1  0 = 24-hour display, 1 = 12-hour display
time_out  out  24  BCD {hr_ms,hr_ls,min_ms,min_ls,sec_ms,sec_ls} in the selected display mode
pm  out  1  1 when internal hour >= 12; valid in both modes
sec_pulse  out  1  one-cycle strobe: seconds advanced
min_pulse  out  1  one-cycle strobe: minute field changed due to an advance
day_pulse  out  1  one-cycle strobe: day rollover
load_err  out  1  one-cycle strobe: load rejected

Behaviour:
- Internal state is six 4-bit BCD registers, always 24-hour, plus the prescale counter pcnt.
- Reset: state 00:00:00, pcnt 0, all pulses 0, load_err 0. time_out = 00:00:00 (24h) or 12:00:00 (12h); pm 0.
- Priority per cycle: reset > load > hold > tick.
- Load valid when every digit is <= 9, hr_ms <= 2, hr_ms == 2 implies hr_ls <= 3, and min_ms <= 5 and sec_ms <= 5.
- Valid load: state <= load_time on the next edge. pcnt <= 0. No pulses.
- Invalid load: state and pcnt are unchanged. load_err = 1 for the next cycle.
- A tick in the same cycle as a load is dropped.
- hold = 1 with no load: ticks are ignored and pcnt is frozen.
- Qualified tick (tick & !hold & !load & !reset):
  - If pcnt == PRESCALE-1, then pcnt <= 0 and the state advances one second.
  - Otherwise pcnt increments.
  - With PRESCALE = 1, every qualified tick advances.
- Advance ripple:
  - sec_ls 9 -> 0 carries into sec_ms.
  - sec_ms 5 -> 0 carries into min_ls. Minutes ripple the same way.
  - Hours: hr_ls 9 -> 0 carries into hr_ms. 23 -> 00 on a carry-in.
  - 23:59:59 -> 00:00:00.
- Pulses are registered and asserted in the cycle the new state is first visible:
  - sec_pulse on every advance.
  - min_pulse when seconds wrap 59 -> 00.
  - day_pulse when the advance produces 00:00:00.
  - Loads never generate pulses, even a load of 00:00:00.
- Display mapping is combinational from state and mode_12h, with zero latency. Hours 00 -> 12, 01-12 unchanged, 13-23 -> 01-11. Minutes and seconds are unchanged. mode_12h may toggle at any time without affecting state.
- The state never holds a non-BCD or out-of-range value.

Optional Feature:
TIME_CNT_DOWN_EN
- Defined: adds input port count_down (1 bit). When count_down = 1, an advance decrements one second.
  - Borrow ripple: sec_ls 0 -> 9, sec_ms 0 -> 5, min likewise, hours 00 -> 23.
  - 00:00:00 -> 23:59:59 asserts day_pulse.
  - min_pulse asserts when seconds wrap 00 -> 59.
  - Prescaler behaviour is identical to count-up.
- Not defined: no count_down port; counting is up only.

Test Plan:
- Reset held 2 cycles with tick = 1 -> time_out 00:00:00, pcnt 0, all pulses 0; with mode_12h = 1, time_out 12:00:00 and pm 0.
- Load 23:59:58, PRESCALE = 1, two ticks -> 23:59:59 with sec_pulse only; then 00:00:00 with sec_pulse, min_pulse and day_pulse all 1 for one cycle.
- PRESCALE = 4, load 00:00:00, 11 ticks -> time_out 00:00:02, sec_pulse seen exactly twice; assert hold for 5 ticks -> no change; release hold, 1 more tick -> 00:00:03.
- Load 24:00:00, then load 12:60:00 -> load_err pulses both times, state unchanged. Load 09:59:59 together with a tick -> 09:59:59, tick dropped.
- mode_12h = 1, load 13:05:00 -> time_out 01:05:00, pm 1. Load 12:00:00 -> 12:00:00, pm 1. Load 00:30:00 -> 12:30:00, pm 0.
- TIME_CNT_DOWN_EN defined, count_down = 1, load 00:00:01, two ticks -> 00:00:00, then 23:59:59 with day_pulse and min_pulse.
